regfile_write_arbiter: RTL and testbench

- Owns the single register-file write port (WE3/A3/WD3) and shares it between two writeback requesters, e.g. core writeback and a load/debug unit.
- Uses a valid/ready handshake and round-robin arbitration.
- Registers the outputs that drive the write port.
- Contains an init sequencer that, after reset, clears registers 1..REG_COUNT-1 before any requester is served.

---
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 tb/tb_regfile_write_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port and shares it round-robin between two writeback requesters.
// After reset an optional init sequencer zeroes registers 1..REG_COUNT-1 before any requester is served.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  init_busy,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] WD3
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(REG_COUNT - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    last_grant;
  logic                    grant0, grant1;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  // On a tie the requester that was not served last wins, so contention alternates.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = (state == RUN) && !rst && grant0;
  assign req1_ready = (state == RUN) && !rst && grant1;
  assign init_busy  = (state == INIT) || rst;

  assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel_addr = grant1 ? req1_addr : req0_addr;
  assign sel_data = grant1 ? req1_data : req0_data;

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == LAST_REG) state_nxt = RUN;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= (INIT_EN != 0) ? INIT : RUN;
      init_cnt   <= ADDR_WIDTH'(1);
      last_grant <= 1'b1;
      WE3        <= 1'b0;
      A3         <= '0;
      WD3        <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        WE3      <= 1'b1;
        A3       <= init_cnt;
        WD3      <= '0;
        init_cnt <= init_cnt + 1'b1;
      end else if (accept) begin
        // x0 is hardwired: the handshake completes but nothing reaches the file.
        WE3        <= (sel_addr != '0);
        A3         <= sel_addr;
        WD3        <= sel_data;
        last_grant <= grant1;
      end else begin
        WE3 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: init clear sequence, round-robin table, x0 drop, mid-init reset, INIT_EN=0 start.
module tb_regfile_write_arbiter;
  localparam int DW = 32, AW = 5, RC = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          rst, v0, v1, r0, r1, busy, we;
  logic [AW-1:0] a0, a1, a3;
  logic [DW-1:0] d0, d1, wd;

  logic          rst_b, v0_b, v1_b, r0_b, r1_b, busy_b, we_b;
  logic [AW-1:0] a0_b, a1_b, a3_b;
  logic [DW-1:0] d0_b, d1_b, wd_b;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .INIT_EN(1)) u_dut (
    .CLK(CLK), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .init_busy(busy), .WE3(we), .A3(a3), .WD3(wd));

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .INIT_EN(0)) u_dut_noinit (
    .CLK(CLK), .rst(rst_b),
    .req0_valid(v0_b), .req0_addr(a0_b), .req0_data(d0_b), .req0_ready(r0_b),
    .req1_valid(v1_b), .req1_addr(a1_b), .req1_data(d1_b), .req1_ready(r1_b),
    .init_busy(busy_b), .WE3(we_b), .A3(a3_b), .WD3(wd_b));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Valids stay asserted throughout to show INIT ignores them.
  task automatic run_init();
    for (int i = 1; i < RC; i++) begin
      #1;
      chk($sformatf("init%0d busy", i), busy, 1'b1);
      chk($sformatf("init%0d ready0", i), r0, 1'b0);
      chk($sformatf("init%0d ready1", i), r1, 1'b0);
      tick();
      chk($sformatf("init%0d we", i), we, 1'b1);
      chk($sformatf("init%0d a3", i), a3, i);
      chk($sformatf("init%0d wd3", i), wd, 32'h0);
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("init_done busy", busy, 1'b0);
  endtask

  typedef struct {
    logic v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic v1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic r0; logic r1; logic we; logic [AW-1:0] a3; logic [DW-1:0] wd;
  } vec_t;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    //        v0  a0 d0        v1  a1 d1         r0 r1 we a3 wd
    vt[0]  = '{0, 0, 32'h0,    1, 7, 32'h77,    0, 1, 1, 7, 32'h77};
    vt[1]  = '{0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 0, 7, 32'h77};
    vt[2]  = '{1, 3, 32'hA,    1, 4, 32'hB,     1, 0, 1, 3, 32'hA};
    vt[3]  = '{1, 3, 32'hA,    1, 4, 32'hB,     0, 1, 1, 4, 32'hB};
    vt[4]  = '{1, 3, 32'hA,    1, 4, 32'hB,     1, 0, 1, 3, 32'hA};
    vt[5]  = '{1, 3, 32'hA,    1, 4, 32'hB,     0, 1, 1, 4, 32'hB};
    vt[6]  = '{1, 5, 32'h1234, 0, 0, 32'h0,     1, 0, 1, 5, 32'h1234};
    vt[7]  = '{0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 0, 5, 32'h1234};
    vt[8]  = '{0, 0, 32'h0,    1, 0, 32'hFFFF,  0, 1, 0, 0, 32'hFFFF};
    vt[9]  = '{1, 3, 32'hA,    1, 4, 32'hB,     1, 0, 1, 3, 32'hA};
    vt[10] = '{0, 0, 32'h0,    0, 0, 32'h0,     0, 0, 0, 3, 32'hA};
    vt[11] = '{1, 3, 32'hA,    1, 4, 32'hB,     0, 1, 1, 4, 32'hB};
    vt[12] = '{1, 0, 32'h5,    0, 0, 32'h0,     1, 0, 0, 0, 32'h5};
    vt[13] = '{1, 3, 32'hA,    1, 4, 32'hB,     0, 1, 1, 4, 32'hB};

    rst = 1'b1; v0 = 1'b1; a0 = 5'd9; d0 = 32'hDEAD; v1 = 1'b1; a1 = 5'd10; d1 = 32'hBEEF;
    rst_b = 1'b1; v0_b = 1'b1; a0_b = 5'd9; d0_b = 32'h99; v1_b = 1'b0; a1_b = '0; d1_b = '0;

    tick(); tick();
    chk("rst we", we, 1'b0);
    chk("rst a3", a3, 5'd0);
    chk("rst wd3", wd, 32'h0);
    chk("rst busy", busy, 1'b1);
    chk("rst ready0", r0, 1'b0);
    chk("rst ready1", r1, 1'b0);
    rst = 1'b0;
    run_init();

    for (int k = 0; k < 14; k++) begin
      v0 = vt[k].v0; a0 = vt[k].a0; d0 = vt[k].d0;
      v1 = vt[k].v1; a1 = vt[k].a1; d1 = vt[k].d1;
      #1;
      chk($sformatf("vec%0d ready0", k), r0, vt[k].r0);
      chk($sformatf("vec%0d ready1", k), r1, vt[k].r1);
      tick();
      chk($sformatf("vec%0d we", k), we, vt[k].we);
      chk($sformatf("vec%0d a3", k), a3, vt[k].a3);
      chk($sformatf("vec%0d wd3", k), wd, vt[k].wd);
    end
    v0 = 1'b0; v1 = 1'b0;

    // Reset landing at init_cnt==10 must abort and restart the clear from register 1.
    v0 = 1'b1; v1 = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick();
      chk($sformatf("pre_abort%0d a3", i), a3, i);
    end
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 1'b1);
    chk("abort ready0", r0, 1'b0);
    tick();
    chk("abort we", we, 1'b0);
    chk("abort a3", a3, 5'd0);
    rst = 1'b0;
    run_init();

    // INIT_EN=0: requester served on the first cycle after reset.
    #1;
    chk("noinit rst busy", busy_b, 1'b1);
    chk("noinit rst ready0", r0_b, 1'b0);
    chk("noinit rst we", we_b, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("noinit busy", busy_b, 1'b0);
    chk("noinit ready0", r0_b, 1'b1);
    chk("noinit ready1", r1_b, 1'b0);
    tick();
    chk("noinit we", we_b, 1'b1);
    chk("noinit a3", a3_b, 5'd9);
    chk("noinit wd3", wd_b, 32'h99);
    v0_b = 1'b0;
    tick();
    chk("noinit idle we", we_b, 1'b0);
    chk("noinit idle a3", a3_b, 5'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
